// File: rtl/wbdbg_byte_framer.sv
// wbdbg_byte_framer: packs 5-byte rx command frames into 36-bit command
// words and serialises queued 36-bit responses into 5-byte tx frames.
// Ports: i_clk/i_reset (sync, active high); i_rx_valid/i_rx_data byte in;
//   o_cmd_valid/i_cmd_ready/o_cmd_data command word out; o_cmd_reset pulse;
//   i_resp_valid/i_resp_data response in; o_tx_valid/o_tx_data/i_tx_ready
//   byte out; o_overflow and o_framing_err one-cycle error pulses.
module wbdbg_byte_framer #(
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic [35:0] o_cmd_data,
    output logic        o_cmd_reset,
    input  logic        i_resp_valid,
    input  logic [35:0] i_resp_data,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_overflow,
    output logic        o_framing_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(RESP_FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0] FIFO_FULL = (AW + 1)'(RESP_FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_SEND} tx_state_t;

    logic [2:0]    r_pos;
    logic [TW-1:0] r_to;
    logic [3:0]    r_nib;
    logic [23:0]   r_shift;
    logic          r_cmd_valid;
    logic [35:0]   r_cmd_data;
    logic          r_cmd_reset;
    logic          r_overflow;
    logic          r_framing_err;
    logic [35:0]   r_mem [RESP_FIFO_DEPTH];
    logic [AW:0]   r_wr;
    logic [AW:0]   r_rd;
    tx_state_t     r_state;
    logic [2:0]    r_idx;
    logic [31:0]   r_word;
    logic          r_tx_valid;
    logic [7:0]    r_tx_data;

    logic        w_hdr;
    logic        w_hdr_rst;
    logic        w_hdr_ok;
    logic        w_hdr_bad;
    logic        w_done;
    logic        w_load;
    logic        w_cmd_drop;
    logic        w_timeout;
    logic        w_empty;
    logic        w_full;
    logic [35:0] w_head;
    logic        w_tx_acc;
    logic        w_last;
    logic        w_pop;
    logic        w_push;
    logic        w_resp_drop;

    assign w_hdr      = (r_pos == 3'd0);
    assign w_hdr_rst  = i_rx_valid & w_hdr & (i_rx_data == 8'hFF);
    assign w_hdr_ok   = i_rx_valid & w_hdr & (i_rx_data[7:4] == 4'hA);
    assign w_hdr_bad  = i_rx_valid & w_hdr & ~w_hdr_rst & ~w_hdr_ok;
    assign w_done     = i_rx_valid & (r_pos == 3'd4);
    assign w_load     = w_done & (~r_cmd_valid | i_cmd_ready);
    assign w_cmd_drop = w_done & ~w_load;
    assign w_timeout  = ~i_rx_valid & ~w_hdr & (r_to == TO_LAST);

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_empty  = (r_wr == r_rd);
    assign w_full   = ((r_wr - r_rd) == FIFO_FULL);
    assign w_head   = r_mem[r_rd[AW-1:0]];
    assign w_tx_acc = r_tx_valid & i_tx_ready;
    assign w_last   = w_tx_acc & (r_idx == 3'd4);
    // A link-reset flush wins over any pop or push in the same cycle.
    assign w_pop    = ~w_hdr_rst & ~w_empty & ((r_state == S_IDLE) | w_last);
    assign w_push   = i_resp_valid & ~w_hdr_rst & (~w_full | w_pop);
    assign w_resp_drop = i_resp_valid & ~w_hdr_rst & w_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pos         <= 3'd0;
            r_to          <= '0;
            r_nib         <= 4'd0;
            r_shift       <= 24'd0;
            r_cmd_valid   <= 1'b0;
            r_cmd_data    <= 36'd0;
            r_cmd_reset   <= 1'b0;
            r_overflow    <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            r_cmd_reset   <= w_hdr_rst;
            r_framing_err <= w_hdr_bad | w_timeout;
            r_overflow    <= w_cmd_drop | w_resp_drop;
            if (i_rx_valid || w_hdr || w_timeout) begin
                r_to <= '0;
            end else begin
                r_to <= r_to + 1'b1;
            end
            if (w_timeout) begin
                r_pos <= 3'd0;
            end else if (w_hdr_ok) begin
                r_pos <= 3'd1;
                r_nib <= i_rx_data[3:0];
            end else if (i_rx_valid && !w_hdr) begin
                r_pos   <= w_done ? 3'd0 : r_pos + 3'd1;
                r_shift <= {r_shift[15:0], i_rx_data};
            end
            // r_shift holds data bytes 1..3; byte 4 arrives directly.
            if (w_load) begin
                r_cmd_valid <= 1'b1;
                r_cmd_data  <= {r_nib, r_shift, i_rx_data};
            end else if (w_hdr_rst || (r_cmd_valid && i_cmd_ready)) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= i_resp_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || w_hdr_rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // The word in flight lives in r_word, so a flush never cuts a frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_word     <= 32'd0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
        end else if (w_pop) begin
            r_state    <= S_SEND;
            r_idx      <= 3'd0;
            r_word     <= w_head[31:0];
            r_tx_valid <= 1'b1;
            r_tx_data  <= {4'hA, w_head[35:32]};
        end else if (w_tx_acc) begin
            if (r_idx == 3'd4) begin
                r_state    <= S_IDLE;
                r_tx_valid <= 1'b0;
            end else begin
                r_idx     <= r_idx + 3'd1;
                r_tx_data <= r_word[31:24];
                r_word    <= {r_word[23:0], 8'd0};
            end
        end
    end

    assign o_cmd_valid   = r_cmd_valid;
    assign o_cmd_data    = r_cmd_data;
    assign o_cmd_reset   = r_cmd_reset;
    assign o_tx_valid    = r_tx_valid;
    assign o_tx_data     = r_tx_data;
    assign o_overflow    = r_overflow;
    assign o_framing_err = r_framing_err;
endmodule

// File: doc/wbdbg_byte_framer.md
# wbdbg_byte_framer

Byte-stream framing stage for the Wishbone debug bus master. It packs 5-byte command frames from the UART receiver into 36-bit command words for the master's command port. It queues the master's 36-bit response pulses in a small FIFO and serialises them as 5-byte frames to the UART transmitter. It also owns the link-level reset byte, inter-byte timeout resynchronisation, and overflow/framing error reporting.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1000000: idle cycles inside a partial command frame before it is discarded; must be ≥ 2.
- RESP_FIFO_DEPTH, default 4: response FIFO entries; power of two, ≥ 2.

Ports:
- i_clk  in  1  clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a received byte. There is no back-pressure.
- i_rx_data  in  8  received byte.
- o_cmd_valid  out  1  o_cmd_data holds a command word.
- i_cmd_ready  in  1  master accepts the command word.
- o_cmd_data  out  36  {cmd[3:0], data[31:0]}.
- o_cmd_reset  out  1  one-cycle link-reset pulse to the master.
- i_resp_valid  in  1  one-cycle response strobe from the master. There is no back-pressure.
- i_resp_data  in  36  {code[3:0], data[31:0]}.
- o_tx_valid  out  1  o_tx_data holds a byte to transmit.
- o_tx_data  out  8  byte to transmit.
- i_tx_ready  in  1  transmitter accepts the byte.
- o_overflow  out  1  one-cycle pulse: a command or response was dropped.
- o_framing_err  out  1  one-cycle pulse: a bad header byte or a timeout occurred.

## Operation
Command receive FSM (position counter pos 0..4):
- pos 0 = HDR state.
  - Byte 0xFF: link reset. Next cycle o_cmd_reset=1 for exactly 1 cycle. The pending command is cleared (o_cmd_valid→0). The response FIFO is flushed. An in-progress tx frame still completes. pos stays 0.
  - Byte with high nibble 0xA: cmd[3:0] is latched from the low nibble; pos→1.
  - Any other byte: ignored; o_framing_err pulse; pos stays 0.
- pos 1..4 = DATA state. Bytes are shifted in MSB-first: data[31:24] first, data[7:0] last. 0xFF is ordinary data here. Byte at pos 4 completes the frame; pos→0.
- Frame completion:
  - If no command is pending, or i_cmd_ready is high that same cycle: o_cmd_data is loaded and o_cmd_valid=1 next cycle.
  - Otherwise the new frame is dropped, o_overflow pulses, and the pending word is unchanged.
- Timeout: counter resets on every accepted rx byte and counts while pos≠0. When it reaches TIMEOUT_CYCLES-1 with no byte that cycle: pos→0, o_framing_err pulses. Counter width is $clog2(TIMEOUT_CYCLES+1).
- o_cmd_data is stable while o_cmd_valid=1. o_cmd_valid drops the cycle after a cycle with o_cmd_valid & i_cmd_ready.

Response path:
- i_resp_valid pushes i_resp_data into the FIFO.
- If the FIFO is full and no pop occurs that cycle, the word is dropped and o_overflow pulses. A push while full with a simultaneous pop is accepted.
- Tx serialiser states: IDLE, SEND with byte index 0..4.
  - Byte 0 = {4'hA, code}; bytes 1..4 = data MSB-first.
  - IDLE with the FIFO non-empty: pop; SEND index 0 next cycle.
  - o_tx_valid/o_tx_data are held stable until i_tx_ready. The index advances on each accepted byte.
  - On acceptance of byte 4: if the FIFO is non-empty, pop at the same edge and present byte 0 of the next word next cycle with no bubble; else go to IDLE.
- Link-reset flush and a master push one cycle later do not conflict: the flush occurs on the edge that raises o_cmd_reset, so the master's BUS_RESET response is retained.

## Timing
- Reset values: o_cmd_valid=0, o_cmd_data=0, o_cmd_reset=0, o_tx_valid=0, o_tx_data=0, o_overflow=0, o_framing_err=0. i_reset also sets pos=0, clears the timeout counter, empties the FIFO, and sets the serialiser to IDLE. i_reset overrides all other events, including mid-frame.
- Latencies:
  - 5th command byte strobe (cycle N) → o_cmd_valid at N+1.
  - 0xFF at HDR (cycle N) → o_cmd_reset at N+1 only.
  - i_resp_valid at cycle N with serialiser IDLE and FIFO empty → o_tx_valid at N+2.
  - Consecutive rx strobes in adjacent cycles are legal.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Bytes A1 12 34 56 78, i_cmd_ready=1 → o_cmd_valid one cycle after the last byte, o_cmd_data=0x1_12345678, then drops.
- Hold i_cmd_ready=0; send A3 00 00 00 10 then A1 00 00 00 00 → o_cmd_data stays 0x3_00000010; o_overflow pulses once after the second frame.
- Send A2 DE AD, then idle TIMEOUT_CYCLES (set to 16) → o_framing_err pulse, no command. Then A7 00 00 00 04 → o_cmd_data=0x7_00000004.
- 0xFF at HDR with a command pending and 2 FIFO entries → o_cmd_reset 1-cycle pulse, o_cmd_valid=0, FIFO empty. 0xFF at pos 2 is treated as data, not a reset.
- i_resp_valid with 0x1_CAFEBABE, i_tx_ready=1 → tx bytes A1 CA FE BA BE, first byte at N+2. With i_tx_ready toggling, o_tx_data must stay stable while stalled.
- DEPTH=4, i_tx_ready=0: push 6 responses in consecutive cycles → the serialiser pops the 1st at N+1, so FIFO holds 2nd..5th; the 6th is dropped with one o_overflow pulse. Release → exactly 25 bytes, back-to-back with no bubbles.
